ghost_move_scheduler: RTL
=========================

# ghost_move_scheduler

Sequences the movement of all ghosts through one shared wall/collision checker port. It replaces the per-ghost checker instances and free-running direction counters. It sits between the game tick and the shared `CheckCollision`-style lookup, and owns every ghost's position and heading. On each movement tick it visits the ghosts in fixed order and queries the checker for each one. A ghost either steps one pixel or picks a new heading and re-queries, bounded at three retries.

## Interface
- `NUM_GHOSTS`, 4: ghosts scheduled, 1..4.
- `TICK_DIV`, 131072: clock cycles between movement ticks, ≥ 16.
- `X0`, 200: reset x of ghost 0; ghost g resets to `X0 + 16*g`.
- `Y0`, 146: reset y of every ghost.
- `LFSR_SEED`, 8'hA5: reset value of the direction LFSR, nonzero.

- `clk`: in, 1. Single clock.
- `rst`: in, 1. Synchronous, active-high reset.
- `enable`: in, 1. Movement ticks are ignored while low.
- `ck_req`: out, 1. Query to the shared checker.
- `ck_x`: out, 10. x of the queried ghost.
- `ck_y`: out, 9. y of the queried ghost.
- `ck_dir`: out, 2. Direction being queried.
- `ck_ack`: in, 1. Checker response valid.
- `ck_free`: in, 1. Qualified by `ck_ack`; 1 means the move is free.
- `ghost_x`: out, 10*NUM_GHOSTS. Packed x positions; ghost g at `[10g+9:10g]`.
- `ghost_y`: out, 9*NUM_GHOSTS. Packed y positions.
- `ghost_dir`: out, 2*NUM_GHOSTS. Packed current headings.
- `busy`: out, 1. High while a pass is in progress.
- `step_done`: out, 1. One-cycle pulse at the end of a pass.
- `overrun`: out, 1. Sticky flag: a tick was dropped.

## Operation
- Direction encoding:
  - 00: up, y−1.
  - 01: down, y+1.
  - 10: left, x−1.
  - 11: right, x+1.
- Position arithmetic is modulo 2^10 for x and 2^9 for y. No clamping; the checker is responsible for walls.
- Prescaler counts 0..TICK_DIV−1 continuously. A tick is generated at the wrap.
  - The tick counts only if `enable` is high in that cycle.
- LFSR: 8 bits, Fibonacci, taps 8,6,5,4. Advances every clock, including in IDLE.
- FSM states:
  - **IDLE**: if `pending` is set, set g=0 and tries=0, then go to REQ.
  - **REQ**: `ck_req`=1 with ghost g's x/y and candidate direction; candidate = `ghost_dir[g]` on the first try.
    - Hold until `ck_ack`=1, then latch `ck_free` and go to EVAL.
  - **EVAL**:
    - If free: commit the candidate to `ghost_dir[g]`, step the position by one pixel, go to NEXT.
    - Else if tries<3: new candidate = `lfsr[1:0]`; if that equals the rejected candidate, use candidate+1 (mod 4). Increment tries and go to REQ.
    - Else: position unchanged, `ghost_dir[g]` = last rejected candidate, go to NEXT.
  - **NEXT**: if g = NUM_GHOSTS−1, pulse `step_done` and go to IDLE. Otherwise g+1, tries=0, go to REQ.
- Tick handling:
  - A tick sets the one-deep `pending` flag; entering REQ from IDLE clears it.
  - A tick arriving while `pending` is already set is dropped and sets `overrun`. `overrun` is cleared only by `rst`.
- `busy` = state ≠ IDLE.
- Reset values:
  - Ghost g: x = X0+16g, y = Y0, dir = g[1:0].
  - `ck_req`=0, `busy`=0, `step_done`=0, `overrun`=0, `pending`=0.
  - Prescaler = 0, LFSR = LFSR_SEED, state IDLE.
- Reset mid-pass: the pass is aborted and `ck_req` drops the next cycle. Positions return to reset values, with no partial commit.

## Timing
- All outputs are registered.
- `ck_x`, `ck_y` and `ck_dir` are stable while `ck_req`=1.
- `ck_ack` is accepted in any cycle in which `ck_req`=1, including the first. There is no timeout.
- `ck_req` is low for at least one cycle (EVAL) between consecutive queries.
- Tick to first `ck_req`:
  - 2 cycles if idle: pending set, then REQ.
  - If busy, the first `ck_req` comes after the current pass's `step_done`.
- Per query with zero-wait ack: 2 cycles (REQ, EVAL). Plus 1 cycle (NEXT) per ghost.
- Best-case pass with all moves free: 3·NUM_GHOSTS cycles after REQ entry.
- Position and dir updates are visible in the cycle after EVAL.
- `step_done` is asserted in the cycle after the NEXT of the last ghost.

## Test plan
- Reset with defaults:
  - `ghost_x` = {248,232,216,200} (ghost 3 first), `ghost_y` all 146, `ghost_dir` = {3,2,1,0}.
  - `busy`=0, `overrun`=0.
- All-free pass (TICK_DIV=16, ack same cycle, `ck_free`=1):
  - Ghost 0 goes to y=145, ghost 1 to y=147, ghost 2 to x=215, ghost 3 to x=249.
  - `step_done` pulses once; 12 REQ/EVAL/NEXT cycles.
- Blocked then free (ghost 0 blocked on first query only):
  - The second `ck_dir` ≠ 0 and comes from the LFSR.
  - Ghost 0 moves one pixel in that direction; `ghost_dir[0]` updated.
- Fully blocked (ghost 1 always `ck_free`=0):
  - Exactly 4 `ck_req` handshakes for ghost 1; its position is unchanged; the pass continues to ghost 2.
- Delayed ack (`ck_ack` 5 cycles after `ck_req`):
  - `ck_req` and `ck_x/y/dir` held stable for 5 cycles; a single handshake per query.
- Overrun and reset:
  - With `ck_ack` stalled across two ticks, `overrun`=1 and stays set.
  - Asserting `rst` mid-REQ drops `ck_req` the next cycle and restores reset positions.
  - With `enable`=0, ticks produce no `ck_req`.

Source files
------------

// File: rtl/ghost_move_scheduler.sv
// Moves every ghost through one shared wall/collision checker port.
// Each movement tick visits the ghosts in order; a blocked ghost re-aims from the LFSR up to three times.
module ghost_move_scheduler #(
    parameter int         NUM_GHOSTS = 4,
    parameter int         TICK_DIV   = 131072,
    parameter logic [9:0] X0         = 10'd200,
    parameter logic [8:0] Y0         = 9'd146,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic                     ck_req,
    output logic [9:0]               ck_x,
    output logic [8:0]               ck_y,
    output logic [1:0]               ck_dir,
    input  logic                     ck_ack,
    input  logic                     ck_free,
    output logic [10*NUM_GHOSTS-1:0] ghost_x,
    output logic [9*NUM_GHOSTS-1:0]  ghost_y,
    output logic [2*NUM_GHOSTS-1:0]  ghost_dir,
    output logic                     busy,
    output logic                     step_done,
    output logic                     overrun
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_NEXT = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [7:0]    lfsr;
    logic          pending;
    logic          free_q;
    logic [GW-1:0] g;
    logic [1:0]    tries;
    logic [1:0]    cand;

    logic          wrap;
    logic          tick;
    int            gi;
    int            gn;
    logic [9:0]    cur_x;
    logic [8:0]    cur_y;
    logic [9:0]    step_x;
    logic [8:0]    step_y;
    logic [9:0]    nxt_x;
    logic [8:0]    nxt_y;
    logic [1:0]    nxt_dir;
    logic [1:0]    alt_dir;

    assign wrap = (presc == PW'(TICK_DIV - 1));
    assign tick = wrap && enable;

    // Current ghost's one-pixel step, the next ghost's state, and the retry heading.
    always_comb begin
        gi      = int'(g);
        gn      = (gi + 1 < NUM_GHOSTS) ? gi + 1 : 0;
        cur_x   = ghost_x[10*gi +: 10];
        cur_y   = ghost_y[9*gi +: 9];
        nxt_x   = ghost_x[10*gn +: 10];
        nxt_y   = ghost_y[9*gn +: 9];
        nxt_dir = ghost_dir[2*gn +: 2];
        step_x  = cur_x;
        step_y  = cur_y;
        case (cand)
            2'b00:   step_y = cur_y - 9'd1;
            2'b01:   step_y = cur_y + 9'd1;
            2'b10:   step_x = cur_x - 10'd1;
            default: step_x = cur_x + 10'd1;
        endcase
        alt_dir = (lfsr[1:0] == cand) ? cand + 2'd1 : lfsr[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            presc     <= '0;
            lfsr      <= LFSR_SEED;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            free_q    <= 1'b0;
            g         <= '0;
            tries     <= '0;
            cand      <= '0;
            ck_req    <= 1'b0;
            ck_x      <= '0;
            ck_y      <= '0;
            ck_dir    <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                ghost_x[10*i +: 10] <= X0 + 10'(16 * i);
                ghost_y[9*i +: 9]   <= Y0;
                ghost_dir[2*i +: 2] <= 2'(i);
            end
        end else begin
            presc     <= wrap ? '0 : presc + 1'b1;
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            step_done <= 1'b0;

            // One-deep tick queue; a second tick before the pass starts is lost.
            if (tick) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        g       <= '0;
                        tries   <= '0;
                        cand    <= ghost_dir[1:0];
                        ck_x    <= ghost_x[9:0];
                        ck_y    <= ghost_y[8:0];
                        ck_dir  <= ghost_dir[1:0];
                        ck_req  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ck_ack) begin
                        free_q <= ck_free;
                        ck_req <= 1'b0;
                        state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (free_q) begin
                        ghost_x[10*gi +: 10] <= step_x;
                        ghost_y[9*gi +: 9]   <= step_y;
                        ghost_dir[2*gi +: 2] <= cand;
                        state                <= S_NEXT;
                    end else if (tries != 2'd3) begin
                        cand   <= alt_dir;
                        ck_dir <= alt_dir;
                        tries  <= tries + 2'd1;
                        ck_req <= 1'b1;
                        state  <= S_REQ;
                    end else begin
                        // Boxed in: stay put but remember the last heading tried.
                        ghost_dir[2*gi +: 2] <= cand;
                        state                <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (g == GW'(NUM_GHOSTS - 1)) begin
                        step_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        g      <= g + 1'b1;
                        tries  <= '0;
                        cand   <= nxt_dir;
                        ck_x   <= nxt_x;
                        ck_y   <= nxt_y;
                        ck_dir <= nxt_dir;
                        ck_req <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
